// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and constants for the PIC acknowledge path
package pic_pkg;

  localparam int LEVEL_W    = 3;
  localparam int VEC_BASE_W = 5;

  // Level reported when the CPU acknowledges with no request pending.
  localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    GAP,
    ACK2
  } seq_state_e;

endpackage

// File: rtl/inta_sequencer_if.sv
// rtl/inta_sequencer_if.sv - request/acknowledge bundle between resolver, CPU and sequencer
interface inta_sequencer_if;
  import pic_pkg::*;

  logic                  init;
  logic                  irq_valid;
  logic [LEVEL_W-1:0]    irq_level;
  logic [VEC_BASE_W-1:0] icw2_base;
  logic                  aeoi;
  logic                  inta_n;

  logic                  int_req;
  logic [7:0]            data_out;
  logic                  data_oe;
  logic [7:0]            isr_set;
  logic [7:0]            irr_clr;
  logic [7:0]            eoi_pulse;
  logic                  busy;
  logic                  abort;

  modport master (
    output init, irq_valid, irq_level, icw2_base, aeoi, inta_n,
    input  int_req, data_out, data_oe, isr_set, irr_clr, eoi_pulse, busy, abort
  );

  modport slave (
    input  init, irq_valid, irq_level, icw2_base, aeoi, inta_n,
    output int_req, data_out, data_oe, isr_set, irr_clr, eoi_pulse, busy, abort
  );

endinterface

// File: rtl/inta_sync.sv
// rtl/inta_sync.sv - INTA_N two-flop synchronizer with registered fall/rise pulses
module inta_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inta_ni,
  output logic fall_o,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic fall_q;
  logic rise_q;

  // Idle-high reset so release of reset never looks like an acknowledge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= inta_ni;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fall_q  <= prev_q & ~sync2_q;
      rise_q  <= ~prev_q & sync2_q;
    end
  end

  assign fall_o = fall_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - two-pulse INTA handshake sequencer; INTA_TIMEOUT_EN adds a stalled-ack abort
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  inta_sequencer_if.slave bus
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  seq_state_e         state_q, state_d;
  logic [LEVEL_W-1:0] lvl_q, lvl_d;
  logic [7:0]         vec_q, vec_d;
  logic               spur_q, spur_d;
  logic [7:0]         isr_set_q, isr_set_d;
  logic [7:0]         irr_clr_q, irr_clr_d;
  logic [7:0]         eoi_q, eoi_d;
  logic               fall;
  logic               rise;

`ifdef INTA_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       abort_q, abort_d;
`else
  logic       unused_cfg;
  assign unused_cfg = ^TO_LIMIT;
`endif

  inta_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inta_ni(bus.inta_n),
    .fall_o (fall),
    .rise_o (rise)
  );

  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    vec_d     = vec_q;
    spur_d    = spur_q;
    isr_set_d = 8'h00;
    irr_clr_d = 8'h00;
    eoi_d     = 8'h00;
`ifdef INTA_TIMEOUT_EN
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: if (bus.irq_valid) state_d = REQ;
      REQ: begin
        // Level is taken at the acknowledge itself, so a late higher-priority request wins.
        if (fall) begin
          state_d = ACK1;
`ifdef INTA_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
          if (bus.irq_valid) begin
            lvl_d     = bus.irq_level;
            spur_d    = 1'b0;
            isr_set_d = 8'd1 << bus.irq_level;
            irr_clr_d = 8'd1 << bus.irq_level;
          end else begin
            lvl_d  = SPURIOUS_LEVEL;
            spur_d = 1'b1;
          end
        end
      end
      ACK1: if (rise) state_d = GAP;
      GAP: begin
        if (fall) begin
          vec_d   = {bus.icw2_base, lvl_q};
          state_d = ACK2;
        end
      end
      ACK2: begin
        if (rise) begin
          state_d = IDLE;
          if (bus.aeoi && !spur_q) eoi_d = 8'd1 << lvl_q;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef INTA_TIMEOUT_EN
    if (state_q == ACK1 || state_q == GAP) begin
      if (cnt_q == TO_LIMIT) begin
        state_d = IDLE;
        abort_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
`endif

    if (bus.init) begin
      state_d   = IDLE;
      isr_set_d = 8'h00;
      irr_clr_d = 8'h00;
      eoi_d     = 8'h00;
`ifdef INTA_TIMEOUT_EN
      abort_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      lvl_q     <= '0;
      vec_q     <= 8'h00;
      spur_q    <= 1'b0;
      isr_set_q <= 8'h00;
      irr_clr_q <= 8'h00;
      eoi_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      vec_q     <= vec_d;
      spur_q    <= spur_d;
      isr_set_q <= isr_set_d;
      irr_clr_q <= irr_clr_d;
      eoi_q     <= eoi_d;
    end
  end

`ifdef INTA_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= 8'd0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end
  assign bus.abort = abort_q;
`else
  assign bus.abort = 1'b0;
`endif

  assign bus.int_req   = (state_q == REQ);
  assign bus.data_oe   = (state_q == ACK2);
  assign bus.data_out  = (state_q == ACK2) ? vec_q : 8'h00;
  assign bus.busy      = (state_q != IDLE);
  assign bus.isr_set   = isr_set_q;
  assign bus.irr_clr   = irr_clr_q;
  assign bus.eoi_pulse = eoi_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// tb/tb_inta_sequencer.sv - directed bench with an acknowledge-progress reference model
module tb_inta_sequencer;

  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 0;

  inta_sequencer_if bus();

  inta_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 'steps' counts handshake edges already honoured in this service cycle.
  bit         m_active;
  int         m_steps;
  int         m_lvl;
  bit         m_spur;
  int         m_vec;
  int         m_wait;
  bit [3:0]   m_samp;
  logic [7:0] e_isr, e_irr, e_eoi;
  bit         e_abort;

  int         n_isr, n_eoi, n_abort, n_oe;
  logic [7:0] rec_isr, rec_irr, rec_eoi, rec_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_steps = 0; m_lvl = 0; m_spur = 0; m_vec = 0; m_wait = 0;
    m_samp = 4'hF;
    e_isr = 8'h00; e_irr = 8'h00; e_eoi = 8'h00; e_abort = 0;
  endtask

  task automatic model_step();
    bit act_fall, act_rise, timed_out;
    // An INTA_N edge first sampled three edges ago is acted on now.
    act_fall = !m_samp[2] &&  m_samp[3];
    act_rise =  m_samp[2] && !m_samp[3];
    m_samp   = {m_samp[2:0], bus.inta_n};
    e_isr = 8'h00; e_irr = 8'h00; e_eoi = 8'h00; e_abort = 0;
    timed_out = 0;
    if (bus.init) begin
      m_active = 0;
    end else if (!m_active) begin
      if (bus.irq_valid) begin
        m_active = 1;
        m_steps  = 0;
      end
    end else begin
`ifdef INTA_TIMEOUT_EN
      if (m_steps == 1 || m_steps == 2) begin
        m_wait++;
        if (m_wait > TO) begin
          timed_out = 1;
          m_active  = 0;
          e_abort   = 1;
        end
      end
`endif
      if (!timed_out) begin
        if (m_steps == 0 && act_fall) begin
          m_spur = !bus.irq_valid;
          m_lvl  = bus.irq_valid ? int'(bus.irq_level) : 7;
          if (bus.irq_valid) begin
            e_isr = 8'(1 << m_lvl);
            e_irr = 8'(1 << m_lvl);
          end
          m_steps = 1;
          m_wait  = 0;
        end else if (m_steps == 1 && act_rise) begin
          m_steps = 2;
        end else if (m_steps == 2 && act_fall) begin
          m_vec   = int'(bus.icw2_base) * 8 + m_lvl;
          m_steps = 3;
        end else if (m_steps == 3 && act_rise) begin
          m_active = 0;
          if (bus.aeoi && !m_spur) e_eoi = 8'(1 << m_lvl);
        end
      end
    end
  endtask

  task automatic compare();
    bit e_int, e_oe;
    e_int = m_active && m_steps == 0;
    e_oe  = m_active && m_steps == 3;
    check("int",   32'(bus.int_req),   32'(e_int));
    check("oe",    32'(bus.data_oe),   32'(e_oe));
    check("data",  32'(bus.data_out),  e_oe ? 32'(m_vec) : 32'h0);
    check("busy",  32'(bus.busy),      32'(m_active));
    check("isr",   32'(bus.isr_set),   32'(e_isr));
    check("irr",   32'(bus.irr_clr),   32'(e_irr));
    check("eoi",   32'(bus.eoi_pulse), 32'(e_eoi));
    check("abort", 32'(bus.abort),     32'(e_abort));
    if (bus.isr_set != 8'h00) begin n_isr++; rec_isr = bus.isr_set; rec_irr = bus.irr_clr; end
    if (bus.eoi_pulse != 8'h00) begin n_eoi++; rec_eoi = bus.eoi_pulse; end
    if (bus.abort) n_abort++;
    if (bus.data_oe) begin n_oe++; rec_data = bus.data_out; end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      if (rst_n && chk_en) compare();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic inta_pulse(input int low, input int high);
    bus.inta_n = 1'b0;
    cyc(low);
    bus.inta_n = 1'b1;
    cyc(high);
  endtask

  task automatic clr_rec();
    n_isr = 0; n_eoi = 0; n_abort = 0; n_oe = 0;
    rec_isr = 8'h00; rec_irr = 8'h00; rec_eoi = 8'h00; rec_data = 8'h00;
  endtask

  task automatic setup(input bit v, input logic [2:0] l, input logic [4:0] b, input bit a);
    bus.irq_valid = v;
    bus.irq_level = l;
    bus.icw2_base = b;
    bus.aeoi      = a;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.init = 1'b0;
    bus.inta_n = 1'b1;
    setup(0, 3'd0, 5'd0, 0);
    clr_rec();
    cyc(2);
    check("rst_int",  32'(bus.int_req),  32'h0);
    check("rst_oe",   32'(bus.data_oe),  32'h0);
    check("rst_data", 32'(bus.data_out), 32'h0);
    check("rst_busy", 32'(bus.busy),     32'h0);
    check("rst_abort",32'(bus.abort),    32'h0);
    rst_n = 1'b1;
    chk_en = 1;
    cyc(2);

    // Basic vector delivery
    clr_rec();
    setup(1, 3'd3, 5'b00001, 0);
    cyc(3);
    inta_pulse(4, 5);
    bus.irq_valid = 1'b0;
    inta_pulse(4, 6);
    check("basic_nisr", 32'(n_isr),    32'd1);
    check("basic_isr",  32'(rec_isr),  32'h08);
    check("basic_irr",  32'(rec_irr),  32'h08);
    check("basic_data", 32'(rec_data), 32'h0B);
    check("basic_neoi", 32'(n_eoi),    32'd0);
    check("basic_idle", 32'(bus.busy), 32'h0);

    // Automatic EOI, request held so INT returns right after
    clr_rec();
    setup(1, 3'd6, 5'b10000, 1);
    cyc(3);
    inta_pulse(4, 5);
    inta_pulse(4, 6);
    check("aeoi_data", 32'(rec_data), 32'h86);
    check("aeoi_eoi",  32'(rec_eoi),  32'h40);
    check("aeoi_neoi", 32'(n_eoi),    32'd1);
    check("aeoi_reint",32'(bus.int_req), 32'h1);
    bus.init = 1'b1; bus.irq_valid = 1'b0;
    cyc(1);
    bus.init = 1'b0;
    cyc(2);

    // Preemption while INT is pending
    clr_rec();
    setup(1, 3'd5, 5'b00010, 0);
    cyc(3);
    bus.irq_level = 3'd1;
    cyc(2);
    inta_pulse(4, 5);
    bus.irq_valid = 1'b0;
    inta_pulse(4, 6);
    check("pre_isr",  32'(rec_isr),      32'h02);
    check("pre_lvl",  32'(rec_data[2:0]), 32'd1);
    check("pre_data", 32'(rec_data),     32'h11);

    // Spurious acknowledge
    clr_rec();
    setup(1, 3'd2, 5'b00100, 1);
    cyc(3);
    bus.irq_valid = 1'b0;
    cyc(3);
    check("spur_int", 32'(bus.int_req), 32'h1);
    inta_pulse(4, 5);
    inta_pulse(4, 6);
    check("spur_nisr", 32'(n_isr),    32'd0);
    check("spur_data", 32'(rec_data), 32'h27);
    check("spur_neoi", 32'(n_eoi),    32'd0);

    // Async reset in ACK2
    clr_rec();
    setup(1, 3'd2, 5'b00011, 0);
    cyc(3);
    inta_pulse(4, 5);
    bus.irq_valid = 1'b0;
    bus.inta_n = 1'b0;
    cyc(5);
    check("rst2_oe_pre",   32'(bus.data_oe),  32'h1);
    check("rst2_data_pre", 32'(bus.data_out), 32'h1A);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_oe",   32'(bus.data_oe),  32'h0);
    check("rst2_int",  32'(bus.int_req),  32'h0);
    check("rst2_busy", 32'(bus.busy),     32'h0);
    bus.inta_n = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // INIT during GAP, later INTA ignored
    clr_rec();
    setup(1, 3'd4, 5'b00101, 0);
    cyc(3);
    inta_pulse(4, 5);
    check("init_gap_busy", 32'(bus.busy),    32'h1);
    check("init_gap_int",  32'(bus.int_req), 32'h0);
    bus.init = 1'b1; bus.irq_valid = 1'b0;
    cyc(1);
    bus.init = 1'b0;
    check("init_idle", 32'(bus.busy), 32'h0);
    inta_pulse(4, 5);
    inta_pulse(4, 5);
    check("init_nisr", 32'(n_isr), 32'd1);
    check("init_noe",  32'(n_oe),  32'd0);
    check("init_busy", 32'(bus.busy), 32'h0);

    // Stalled acknowledge: only the first INTA arrives
    clr_rec();
    setup(1, 3'd0, 5'b00000, 0);
    cyc(2);
    inta_pulse(4, 5);
    bus.irq_valid = 1'b0;
    cyc(30);
    check("to_isr", 32'(rec_isr), 32'h01);
`ifdef INTA_TIMEOUT_EN
    check("to_nabort", 32'(n_abort),  32'd1);
    check("to_busy",   32'(bus.busy), 32'h0);
`else
    check("to_nabort", 32'(n_abort),  32'd0);
    check("to_busy",   32'(bus.busy), 32'h1);
`endif
    bus.init = 1'b1;
    cyc(1);
    bus.init = 1'b0;
    cyc(3);
    check("end_busy", 32'(bus.busy), 32'h0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
# inta_sequencer

Interrupt-acknowledge sequencer sitting directly downstream of the PIC priority/request/in-service block. It takes the resolved request (valid + level), raises INT to the CPU, and runs the two-pulse 8086-style INTA handshake. During that handshake it commits the level to ISR, clears the IRR bit, and drives the 8-bit vector `{ICW2_BASE, level}` onto the data bus. In AEOI mode it also issues the automatic end-of-interrupt.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed from first INTA fall to second INTA fall (used only with the timeout feature); 8-bit counter.

Ports:
- CLK  in  1  single system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- INIT  in  1  synchronous abort (ICW1 write); returns to IDLE next cycle.
- IRQ_VALID  in  1  resolver has an unmasked request eligible for service.
- IRQ_LEVEL  in  3  level of that request (0 = IR0).
- ICW2_BASE  in  5  vector bits T7..T3 from ICW2.
- AEOI  in  1  automatic EOI mode enable.
- INTA_N  in  1  CPU acknowledge, active-low, asynchronous to CLK.
- INT  out  1  interrupt request to CPU.
- DATA_OUT  out  8  vector byte.
- DATA_OE  out  1  data-bus drive enable for DATA_OUT.
- ISR_SET  out  8  one-hot, one-cycle pulse: set this ISR bit.
- IRR_CLR  out  8  one-hot, one-cycle pulse: clear this IRR bit (edge mode).
- EOI_PULSE  out  8  one-hot, one-cycle pulse: clear this ISR bit (AEOI only).
- BUSY  out  1  sequencer not in IDLE.
- ABORT  out  1  one-cycle pulse on timeout abort (0 when feature absent).

## Operation
- INTA_N passes through a 2-flop synchronizer. A fall or rise is detected when the synchronized value differs from its previous-cycle copy.
- States: IDLE, REQ, ACK1, GAP, ACK2.
- IDLE: if IRQ_VALID, go to REQ.
- REQ: INT=1. IRQ_LEVEL is tracked each cycle, so a higher-priority request may preempt.
  - On fall detect with IRQ_VALID=1: latch LVL=IRQ_LEVEL, pulse ISR_SET[LVL] and IRR_CLR[LVL], go to ACK1.
  - On fall detect with IRQ_VALID=0 (spurious): LVL=7, no ISR_SET/IRR_CLR, go to ACK1.
  - If IRQ_VALID drops and no fall is detected, INT stays high. The spurious path covers this case.
- ACK1: INT=0. On rise, go to GAP.
- GAP: on fall, latch VEC={ICW2_BASE, LVL} and go to ACK2.
- ACK2: DATA_OE=1, DATA_OUT=VEC. On rise, go to IDLE. If AEOI=1 and the cycle was not spurious, pulse EOI_PULSE[LVL].
- INIT=1 in any state: go to IDLE next edge. All outputs are 0 from that edge. No pulses are issued.
- RST_N low in any state: immediately IDLE. All outputs 0; LVL=0, VEC=0, counter=0.

## Timing
- Reset values: INT=0, DATA_OUT=8'h00, DATA_OE=0, ISR_SET=0, IRR_CLR=0, EOI_PULSE=0, BUSY=0, ABORT=0.
- IRQ_VALID high at edge n: INT=1 from edge n+1 (state REQ).
- INTA_N fall, first sampled at edge k: detect at edge k+2. From edge k+3: state ACK1, INT=0, ISR_SET/IRR_CLR high for exactly one cycle.
- Second fall detected at edge m: DATA_OE=1 and DATA_OUT valid from edge m+1. Both are held until the cycle after rise detection, then return to 0.
- EOI_PULSE is high for the one cycle coincident with the ACK2-to-IDLE transition.
- From IDLE with IRQ_VALID held high, INT re-asserts one cycle after returning to IDLE. There is no back-to-back skip.
- INTA_N glitches shorter than one CLK period may be missed. This is acceptable; CPU INTA pulses are at least 2 cycles.

## Configuration
- INTA_TIMEOUT_EN defined:
  - An 8-bit counter runs in ACK1 and GAP, clearing on entry to ACK1.
  - When the counter reaches TIMEOUT_CYCLES, the sequencer goes to IDLE, pulses ABORT for 1 cycle, and drives DATA_OE=0.
  - ISR already set stays set; clearing it is software's responsibility.
- INTA_TIMEOUT_EN undefined: no counter, ABORT tied 0, and GAP waits indefinitely.

## Structure
- Shared package pic_pkg holds:
  - state enum (IDLE, REQ, ACK1, GAP, ACK2);
  - constant SPURIOUS_LEVEL=3'd7;
  - widths LEVEL_W=3, VEC_BASE_W=5.
- One sub-module, inta_sync: 2-flop synchronizer plus previous-value register, outputting fall/rise pulses, with async active-low reset to 1 (INTA_N idle-high).
- Level-to-one-hot decode is done inline.

## Test plan
- Basic: IRQ_VALID=1, LEVEL=3, ICW2_BASE=5'b00001, AEOI=0; two INTA pulses → ISR_SET=8'h08 and IRR_CLR=8'h08 once, DATA_OUT=8'h0B with DATA_OE only during the second INTA, no EOI_PULSE, back to IDLE.
- AEOI: same with AEOI=1, LEVEL=6, ICW2_BASE=5'b10000 → DATA_OUT=8'h86; EOI_PULSE=8'h40 one cycle after the second INTA rises.
- Preemption: LEVEL=5 in REQ, changes to 1 before first INTA → ISR_SET=8'h02, DATA_OUT low bits = 3'd1.
- Spurious: IRQ_VALID drops to 0 in REQ, then INTA pair → no ISR_SET/IRR_CLR, DATA_OUT={ICW2_BASE,3'd7}, no EOI even with AEOI=1.
- Reset and INIT mid-operation:
  - RST_N low during ACK2 → DATA_OE and INT drop to 0 immediately, state IDLE;
  - INIT during GAP → IDLE next edge, a subsequent INTA is ignored.
- Timeout (INTA_TIMEOUT_EN, TIMEOUT_CYCLES=16): first INTA only → ABORT pulses exactly once at count 16, BUSY=0 afterwards; without the macro, BUSY stays 1.
